// File: rtl/spi_word_serializer.sv
// spi_word_serializer: parallel-to-serial SPI (mode 0) transmit engine.
// A rising edge on ser_trigger latches data_in. The word is then shifted out
// inside a chip-select frame, and done pulses once when the frame ends.
// ser_reset aborts a frame synchronously and never produces done.
// Optional build macro SPI_SERIALIZER_LSB_FIRST_EN: transmit LSB first
// (default: MSB first). Timing and framing are the same in both builds.
module spi_word_serializer #(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_reset,
    input  logic             ser_trigger,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             spi_cs_n,
    output logic             spi_sclk,
    output logic             spi_mosi
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SHIFT_LO = 3'd1;
    localparam logic [2:0] S_SHIFT_HI = 3'd2;
    localparam logic [2:0] S_HOLD     = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             trig_q, trig_d;
    logic             cs_n_q, cs_n_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             first_bit;
    logic [WIDTH-1:0] shifted;
    logic             next_bit;
    logic             phase_end;

    // Bit order: which end of the word goes out first and which way the register moves.
`ifdef SPI_SERIALIZER_LSB_FIRST_EN
    assign first_bit = data_in[0];
    assign shifted   = shreg_q >> 1;
    assign next_bit  = shifted[0];
`else
    assign first_bit = data_in[WIDTH-1];
    assign shifted   = shreg_q << 1;
    assign next_bit  = shifted[WIDTH-1];
`endif

    assign phase_end = (div_q == DIV_LAST);

    // Next-state logic: frame sequencing, with ser_reset overriding everything last.
    always_comb begin
        state_d = state_q;
        div_d   = div_q + DIV_W'(1);
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        trig_d  = ser_trigger;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                div_d = '0;
                if (ser_trigger && !trig_q) begin
                    state_d = S_SHIFT_LO;
                    shreg_d = data_in;
                    cnt_d   = CNT_LOAD;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    sclk_d  = 1'b0;
                    mosi_d  = first_bit;
                end
            end
            S_SHIFT_LO: begin
                if (phase_end) begin
                    state_d = S_SHIFT_HI;
                    div_d   = '0;
                    sclk_d  = 1'b1;
                end
            end
            S_SHIFT_HI: begin
                if (phase_end) begin
                    div_d  = '0;
                    sclk_d = 1'b0;
                    if (cnt_q != '0) begin
                        state_d = S_SHIFT_LO;
                        shreg_d = shifted;
                        mosi_d  = next_bit;
                        cnt_d   = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = S_HOLD;
                        mosi_d  = 1'b0;
                    end
                end
            end
            S_HOLD: begin
                if (phase_end) begin
                    state_d = S_DONE;
                    div_d   = '0;
                    cs_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                // Trigger edges here are dropped; the edge register still tracks the input.
                state_d = S_IDLE;
                div_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                div_d   = '0;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        if (ser_reset) begin
            state_d = S_IDLE;
            div_d   = '0;
            cnt_d   = '0;
            shreg_d = '0;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    // State and registered outputs, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            shreg_q <= '0;
            trig_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            trig_q  <= trig_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign spi_cs_n = cs_n_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_word_serializer.sv
// Bench for spi_word_serializer: DUT 0 is WIDTH=16/CLK_DIV=4, DUT 1 is WIDTH=2/CLK_DIV=1.
// A negedge monitor rebuilds each frame from the SPI pins; expected words are queued
// at trigger time and compared when a frame completes.
module tb_spi_word_serializer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ser_reset = 1'b0;
    logic        trig [2];
    logic [15:0] din0 = 16'h0;
    logic [1:0]  din1 = 2'b0;
    logic        busy [2];
    logic        done [2];
    logic        cs_n [2];
    logic        sclk [2];
    logic        mosi [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          done_cnt [2];
    int          done_cyc [2];
    logic [15:0] cap [2];
    int          rises [2];
    int          cslen [2];
    logic        psclk [2];
    logic        pcs [2];
    logic [15:0] exp_q [2][$];
    logic [15:0] cap_q [2][$];
    int          len_q [2][$];
    int          rise_q [2][$];

    spi_word_serializer #(.WIDTH(16), .CLK_DIV(4)) u_dut0 (
        .clk(clk), .reset(reset), .ser_reset(ser_reset), .ser_trigger(trig[0]),
        .data_in(din0), .busy(busy[0]), .done(done[0]), .spi_cs_n(cs_n[0]),
        .spi_sclk(sclk[0]), .spi_mosi(mosi[0])
    );

    spi_word_serializer #(.WIDTH(2), .CLK_DIV(1)) u_dut1 (
        .clk(clk), .reset(reset), .ser_reset(ser_reset), .ser_trigger(trig[1]),
        .data_in(din1), .busy(busy[1]), .done(done[1]), .spi_cs_n(cs_n[1]),
        .spi_sclk(sclk[1]), .spi_mosi(mosi[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        trig[0] = 1'b0;
        trig[1] = 1'b0;
        for (int g = 0; g < 2; g++) begin
            done_cnt[g] = 0;
            done_cyc[g] = 0;
            cap[g]      = 16'h0;
            rises[g]    = 0;
            cslen[g]    = 0;
            psclk[g]    = 1'b0;
            pcs[g]      = 1'b1;
        end
    end

    // Frame monitor: sample MOSI on each SCLK rise inside CS, log the frame on done.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!cs_n[g] && pcs[g]) begin
                cap[g]   <= 16'h0;
                rises[g] <= 0;
                cslen[g] <= 1;
            end else if (!cs_n[g]) begin
                cslen[g] <= cslen[g] + 1;
                if (sclk[g] && !psclk[g]) begin
                    cap[g]   <= {cap[g][14:0], mosi[g]};
                    rises[g] <= rises[g] + 1;
                end
            end
            if (done[g]) begin
                done_cnt[g] <= done_cnt[g] + 1;
                done_cyc[g] <= cyc;
                cap_q[g].push_back(cap[g]);
                len_q[g].push_back(cslen[g]);
                rise_q[g].push_back(rises[g]);
            end
            psclk[g] <= sclk[g];
            pcs[g]   <= cs_n[g];
        end
    end

    // Expected bit stream as the monitor assembles it (first bit lands highest).
    function automatic logic [15:0] model(input logic [15:0] v, input int w);
        logic [15:0] r;
        r = 16'h0;
`ifdef SPI_SERIALIZER_LSB_FIRST_EN
        for (int i = 0; i < w; i++) r[w-1-i] = v[i];
`else
        for (int i = 0; i < w; i++) r[i] = v[i];
`endif
        return r;
    endfunction

    // One-cycle trigger pulse; returns at the negedge right after the accepting edge.
    task automatic pulse(input int d, input logic [15:0] v, input bit expect_frame, output int t0);
        @(negedge clk);
        trig[d] = 1'b1;
        if (d == 0) din0 = v;
        else din1 = v[1:0];
        @(posedge clk);
        #1;
        t0 = cyc;
        if (expect_frame) exp_q[d].push_back(model(v, (d == 0) ? 16 : 2));
        @(negedge clk);
        trig[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int budget, output bit ok);
        int start;
        start = done_cnt[d];
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt[d] != start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({busy[g], done[g], cs_n[g], sclk[g], mosi[g]} !== 5'b00100) begin
                errors++;
                $display("FAIL reset_values dut%0d: got busy/done/cs_n/sclk/mosi=%b want 00100", g,
                         {busy[g], done[g], cs_n[g], sclk[g], mosi[g]});
            end
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_frame();
        int t0;
        bit ok;
        logic [15:0] e, c;
        int l, r;
        pulse(0, 16'hA5C3, 1'b1, t0);
        checks++;
        if (cs_n[0] !== 1'b0 || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL basic_start: cs_n=%b busy=%b want cs_n=0 busy=1", cs_n[0], busy[0]);
        end
        wait_done(0, 300, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_timeout: no done within 300 cycles");
        end else begin
            e = exp_q[0].pop_front();
            c = cap_q[0].pop_front();
            l = len_q[0].pop_front();
            r = rise_q[0].pop_front();
            checks++;
            if (c !== e) begin
                errors++;
                $display("FAIL basic_word: got %h want %h", c, e);
            end
            checks++;
            if (l != 132) begin
                errors++;
                $display("FAIL basic_cs_len: got %0d want 132", l);
            end
            checks++;
            if (r != 16) begin
                errors++;
                $display("FAIL basic_sclk_rises: got %0d want 16", r);
            end
            checks++;
            if (done_cyc[0] - t0 != 132) begin
                errors++;
                $display("FAIL basic_done_latency: got %0d want 132", done_cyc[0] - t0);
            end
            @(negedge clk);
            checks++;
            if (done[0] !== 1'b0 || cs_n[0] !== 1'b1 || busy[0] !== 1'b0) begin
                errors++;
                $display("FAIL basic_after_done: done=%b cs_n=%b busy=%b want 0 1 0", done[0], cs_n[0], busy[0]);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_no_retrigger();
        int t0, start;
        bit ok;
        logic [15:0] e, c;
        start = done_cnt[0];
        @(negedge clk);
        trig[0] = 1'b1;
        din0 = 16'h1234;
        @(posedge clk);
        #1;
        t0 = cyc;
        exp_q[0].push_back(model(16'h1234, 16));
        repeat (299) @(negedge clk);
        trig[0] = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (done_cnt[0] - start != 1) begin
            errors++;
            $display("FAIL held_done_count: got %0d want 1", done_cnt[0] - start);
        end
        if (cap_q[0].size() > 0 && exp_q[0].size() > 0) begin
            e = exp_q[0].pop_front();
            c = cap_q[0].pop_front();
            void'(len_q[0].pop_front());
            void'(rise_q[0].pop_front());
            checks++;
            if (c !== e) begin
                errors++;
                $display("FAIL held_word: got %h want %h", c, e);
            end
        end
        while (cap_q[0].size() > 0) begin
            void'(cap_q[0].pop_front());
            void'(len_q[0].pop_front());
            void'(rise_q[0].pop_front());
        end
        exp_q[0].delete();

        start = done_cnt[0];
        pulse(0, 16'h0F0F, 1'b1, t0);
        repeat (49) @(negedge clk);
        trig[0] = 1'b1;
        din0 = 16'hFFFF;
        @(negedge clk);
        trig[0] = 1'b0;
        wait_done(0, 300, ok);
        repeat (200) @(negedge clk);
        #1;
        checks++;
        if (done_cnt[0] - start != 1) begin
            errors++;
            $display("FAIL busy_trigger_done_count: got %0d want 1", done_cnt[0] - start);
        end
        if (cap_q[0].size() > 0 && exp_q[0].size() > 0) begin
            e = exp_q[0].pop_front();
            c = cap_q[0].pop_front();
            void'(len_q[0].pop_front());
            void'(rise_q[0].pop_front());
            checks++;
            if (c !== e) begin
                errors++;
                $display("FAIL busy_trigger_word: got %h want %h", c, e);
            end
        end
    endtask

    task automatic test_ser_reset();
        int t0, start;
        bit ok;
        logic [15:0] e, c;
        int l;
        start = done_cnt[0];
        pulse(0, 16'h5A5A, 1'b0, t0);
        repeat (39) @(negedge clk);
        ser_reset = 1'b1;
        @(negedge clk);
        ser_reset = 1'b0;
        checks++;
        if ({cs_n[0], sclk[0], busy[0], mosi[0], done[0]} !== 5'b10000) begin
            errors++;
            $display("FAIL ser_reset_outputs: cs_n/sclk/busy/mosi/done=%b want 10000",
                     {cs_n[0], sclk[0], busy[0], mosi[0], done[0]});
        end
        repeat (4) @(negedge clk);
        pulse(0, 16'hBEEF, 1'b1, t0);
        wait_done(0, 300, ok);
        repeat (150) @(negedge clk);
        #1;
        checks++;
        if (done_cnt[0] - start != 1) begin
            errors++;
            $display("FAIL ser_reset_done_count: got %0d want 1", done_cnt[0] - start);
        end
        if (cap_q[0].size() > 0 && exp_q[0].size() > 0) begin
            e = exp_q[0].pop_front();
            c = cap_q[0].pop_front();
            l = len_q[0].pop_front();
            void'(rise_q[0].pop_front());
            checks++;
            if (c !== e || l != 132) begin
                errors++;
                $display("FAIL ser_reset_refire: word %h len %0d want %h len 132", c, l, e);
            end
        end
    endtask

    task automatic test_async_reset();
        int t0, start;
        bit found;
        start = done_cnt[0];
        pulse(0, 16'h3C3C, 1'b0, t0);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sclk[0]) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL async_find_shift_hi: sclk never rose within 100 cycles");
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy[0], done[0], cs_n[0], sclk[0], mosi[0]} !== 5'b00100) begin
            errors++;
            $display("FAIL async_reset_values: busy/done/cs_n/sclk/mosi=%b want 00100",
                     {busy[0], done[0], cs_n[0], sclk[0], mosi[0]});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        ser_reset = 1'b1;
        trig[0] = 1'b1;
        din0 = 16'h8001;
        @(negedge clk);
        ser_reset = 1'b0;
        checks++;
        if (busy[0] !== 1'b0 || cs_n[0] !== 1'b1) begin
            errors++;
            $display("FAIL ser_reset_vs_trigger: busy=%b cs_n=%b want 0 1", busy[0], cs_n[0]);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL held_after_ser_reset: busy=%b want 0", busy[0]);
        end
        trig[0] = 1'b0;
        repeat (200) @(negedge clk);
        #1;
        checks++;
        if (done_cnt[0] - start != 0) begin
            errors++;
            $display("FAIL async_no_done: got %0d done pulses want 0", done_cnt[0] - start);
        end
    endtask

    task automatic test_div1();
        int t0;
        bit ok;
        logic [15:0] e, c;
        int l, r;
        logic [4:0] pat;
        pat = 5'b01010;
        pulse(1, 16'h0002, 1'b1, t0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (sclk[1] !== pat[4-k] || cs_n[1] !== 1'b0) begin
                errors++;
                $display("FAIL div1_sclk_k%0d: sclk=%b cs_n=%b want sclk=%b cs_n=0", k, sclk[1], cs_n[1], pat[4-k]);
            end
        end
        wait_done(1, 10, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL div1_timeout: no done within 10 cycles");
        end else begin
            e = exp_q[1].pop_front();
            c = cap_q[1].pop_front();
            l = len_q[1].pop_front();
            r = rise_q[1].pop_front();
            checks++;
            if (c !== e || r != 2) begin
                errors++;
                $display("FAIL div1_word: got %h (%0d rises) want %h (2 rises)", c, r, e);
            end
            checks++;
            if (l != 5 || done_cyc[1] - t0 != 5) begin
                errors++;
                $display("FAIL div1_timing: cs len %0d latency %0d want 5 5", l, done_cyc[1] - t0);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_no_retrigger();
        test_ser_reset();
        test_async_reset();
        test_div1();
        checks++;
        if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d/%0d expected frames never seen",
                     exp_q[0].size(), exp_q[1].size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_word_serializer.md
# spi_word_serializer

Parallel-to-serial SPI transmit engine sitting downstream of the serializer sequencing controller. The controller issues a one-cycle `ser_reset` pulse, waits, then issues a one-cycle `ser_trigger` pulse. On the trigger, this block latches a parallel word and shifts it out on a chip-select-framed SPI bus (`spi_cs_n`/`spi_sclk`/`spi_mosi`, mode 0). When the word is complete it reports back with a `done` pulse.

## Interface
Parameters:
- `WIDTH`, default 16: word length in bits; legal range ≥ 2.
- `CLK_DIV`, default 4: `clk` cycles per SCLK half-period; legal range ≥ 1.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ser_reset`  in  1  synchronous abort/clear from the sequencing controller.
- `ser_trigger`  in  1  start request; acted on at its rising edge.
- `data_in`  in  `WIDTH`  word to transmit; sampled on the accepted trigger cycle only.
- `busy`  out  1  high while a frame is in progress.
- `done`  out  1  one-cycle pulse at the end of a frame.
- `spi_cs_n`  out  1  chip select, active low.
- `spi_sclk`  out  1  serial clock; idles low.
- `spi_mosi`  out  1  serial data; changes only while `spi_sclk` is low.

## Operation
- States: `IDLE`, `SHIFT_LO`, `SHIFT_HI`, `HOLD`, `DONE`. All outputs are registered.
- Reset values (`reset` high, asynchronous): state `IDLE`, `spi_cs_n`=1, `spi_sclk`=0, `spi_mosi`=0, `busy`=0, `done`=0, shift register 0, bit counter 0, divider 0, trigger edge register 0.
- Trigger detection: a start is accepted only on a rising edge, i.e. `ser_trigger`=1 with its previous registered value 0.
  - A trigger held high does not retrigger.
  - Any trigger edge while `busy`=1 is ignored; no queueing.
- `IDLE` → `SHIFT_LO` on an accepted edge. On the same edge:
  - latch `data_in` into the shift register;
  - load the bit counter with `WIDTH`-1;
  - register `spi_cs_n`=0, `busy`=1, `spi_mosi`=MSB.
- `SHIFT_LO`: `spi_sclk`=0 for `CLK_DIV` cycles, then go to `SHIFT_HI`.
- `SHIFT_HI`: `spi_sclk`=1 for `CLK_DIV` cycles. At the end of the phase:
  - counter ≠ 0: shift left, drive the next bit on `spi_mosi` together with the falling SCLK edge, decrement the counter, go to `SHIFT_LO`;
  - counter = 0: go to `HOLD` with `spi_sclk`=0 and `spi_mosi`=0.
- `HOLD`: `spi_cs_n` stays 0 for `CLK_DIV` cycles, then go to `DONE`.
- `DONE` (one cycle): `spi_cs_n`=1, `busy`=0, `done`=1. The next state is `IDLE` and `done` returns to 0. A trigger edge seen during `DONE` is ignored.
- `ser_reset`=1 (synchronous, checked every cycle) takes priority over everything, including a simultaneous trigger:
  - the next state is `IDLE` with all outputs at their reset values;
  - no `done` is issued;
  - the trigger edge register is updated normally.
- Divider: counts 0..`CLK_DIV`-1. It is reset to 0 on every phase change.

## Timing
- The accepted trigger is sampled at edge T0.
- `spi_cs_n` falls and `busy` rises in cycle T0+1.
- First SCLK rising edge: T0+1+`CLK_DIV`.
- Each bit occupies 2·`CLK_DIV` cycles. The receiver samples on the rising SCLK edge; data is stable for `CLK_DIV` cycles before and after it.
- `spi_cs_n` is low for exactly (2·`WIDTH`+1)·`CLK_DIV` cycles.
- `done` is high in cycle T0+1+(2·`WIDTH`+1)·`CLK_DIV`.
- Earliest next accepted trigger edge: the cycle after `DONE`.
- `CLK_DIV`=1 is legal: SCLK runs at `clk`/2.

## Configuration
- `SPI_SERIALIZER_LSB_FIRST_EN`:
  - defined: bits are transmitted LSB first; the shift register shifts right and `spi_mosi` takes bit 0;
  - undefined (default): MSB first, as described above.
- Timing, framing and `done` behaviour are identical in both builds.

## Test plan
- `WIDTH`=16, `CLK_DIV`=4, `data_in`=0xA5C3, single trigger pulse → bits captured on SCLK rising edges read 0xA5C3 MSB-first; `spi_cs_n` low 132 cycles; `done` high for 1 cycle at T0+133; 16 SCLK rising edges.
- Same stimulus built with `SPI_SERIALIZER_LSB_FIRST_EN` → the captured bit stream is 0xC3A5 bit-reversed, i.e. the first bit is 1 (bit 0 of 0xA5C3).
- Trigger held high for 300 cycles → exactly one frame and one `done`. A second pulse during the frame at T0+50 → ignored; total `done` count is 1.
- `ser_reset` pulse at T0+40 → the next cycle shows `spi_cs_n`=1, `spi_sclk`=0, `busy`=0; no `done`. A new trigger 5 cycles later → a full, correct frame.
- `reset` asserted asynchronously mid-`SHIFT_HI` → outputs reach reset values without waiting for a `clk` edge. `ser_reset` and a trigger edge in the same cycle → stays in `IDLE`.
- `CLK_DIV`=1, `WIDTH`=2, `data_in`=2'b10 → SCLK toggles every cycle; MOSI captured as 1 then 0; `done` at T0+6.
